// File: rtl/morse_blinker.sv
// Morse letter blinker: an en rising edge plays the Morse pattern for letter A..H
// (selected by sw_i) on two LEDs, ss_o for dots and ls_o for dashes.
module morse_blinker #(
    parameter int unsigned UNIT_CYCLES = 25_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [2:0] sw_i,
    output logic       ss_o,
    output logic       ls_o
);

    // Counter only has to reach 3*UNIT_CYCLES-1 (last cycle of a dash).
    localparam int unsigned CntW = $clog2(3 * UNIT_CYCLES);
    localparam logic [CntW-1:0] DotLast  = CntW'(UNIT_CYCLES - 1);
    localparam logic [CntW-1:0] DashLast = CntW'(3 * UNIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StOn, StGap} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      code_q, code_d;
    logic [2:0]      len_q, len_d;
    logic            en_q;
    logic            ss_q, ss_d;
    logic            ls_q, ls_d;

    logic [3:0]      dec_code;
    logic [2:0]      dec_len;
    logic [CntW-1:0] sym_last;
    logic            last_sym;

    // Decoder: code bit 0 is the first symbol, 1 = dash.
    always_comb begin
        dec_code = 4'b0000;
        dec_len  = 3'd1;
        unique case (sw_i)
            3'd0: begin dec_code = 4'b0010; dec_len = 3'd2; end // A .-
            3'd1: begin dec_code = 4'b0001; dec_len = 3'd4; end // B -...
            3'd2: begin dec_code = 4'b0101; dec_len = 3'd4; end // C -.-.
            3'd3: begin dec_code = 4'b0001; dec_len = 3'd3; end // D -..
            3'd4: begin dec_code = 4'b0000; dec_len = 3'd1; end // E .
            3'd5: begin dec_code = 4'b0100; dec_len = 3'd4; end // F ..-.
            3'd6: begin dec_code = 4'b0011; dec_len = 3'd3; end // G --.
            3'd7: begin dec_code = 4'b0000; dec_len = 3'd4; end // H ....
            default: ;
        endcase
    end

    assign sym_last = code_q[idx_q] ? DashLast : DotLast;
    assign last_sym = (({1'b0, idx_q} + 3'd1) == len_q);

    // Next-state logic; the counter restarts from zero on every state entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        code_d  = code_q;
        len_d   = len_q;
        ss_d    = 1'b0;
        ls_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en_i && !en_q) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                code_d  = dec_code;
                len_d   = dec_len;
                idx_d   = 2'd0;
                cnt_d   = '0;
                state_d = StOn;
            end
            StOn: begin
                ss_d = !code_q[idx_q];
                ls_d = code_q[idx_q];
                if (cnt_q == sym_last) begin
                    cnt_d   = '0;
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StGap: begin
                if (cnt_q == DotLast) begin
                    cnt_d = '0;
                    if (last_sym) begin
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = StOn;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, datapath and registered LED outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            code_q  <= 4'b0000;
            len_q   <= 3'd0;
            en_q    <= 1'b0;
            ss_q    <= 1'b0;
            ls_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            len_q   <= len_d;
            en_q    <= en_i;
            ss_q    <= ss_d;
            ls_q    <= ls_d;
        end
    end

    assign ss_o = ss_q;
    assign ls_o = ls_q;

endmodule

// File: tb/tb_morse_blinker.sv
// Bench for morse_blinker: two instances (unit 2 and unit 1) checked every cycle
// against a queue-based model built from the letters' dot/dash strings.
module tb_morse_blinker;

    logic       clk = 1'b0;
    logic       rst;
    logic       en0, en1;
    logic [2:0] sw0, sw1;
    logic       ss0, ls0, ss1, ls1;

    always #5 clk = ~clk;

    morse_blinker #(.UNIT_CYCLES(2)) dut0 (
        .clk_i(clk), .rst_i(rst), .en_i(en0), .sw_i(sw0), .ss_o(ss0), .ls_o(ls0)
    );
    morse_blinker #(.UNIT_CYCLES(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .en_i(en1), .sw_i(sw1), .ss_o(ss1), .ls_o(ls1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    string morse [8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

    // Model state per instance: expected {ss,ls} for upcoming edges.
    logic [1:0] mq [2][$];
    bit         pend [2];
    bit         enp [2];
    logic [1:0] expv [2];

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got ss,ls=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void build(int i, logic [2:0] s);
        string m = morse[s];
        int    u = (i == 0) ? 2 : 1;
        for (int k = 0; k < m.len(); k++) begin
            bit dash = (m[k] == "-");
            repeat (dash ? 3 * u : u) mq[i].push_back(dash ? 2'b01 : 2'b10);
            repeat (u) mq[i].push_back(2'b00);
        end
    endfunction

    // Model step at each edge, then compare both instances just after it.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic       e;
            logic [2:0] s;
            e = (i == 0) ? en0 : en1;
            s = (i == 0) ? sw0 : sw1;
            if (rst) begin
                mq[i].delete();
                pend[i] = 1'b0;
                enp[i]  = 1'b0;
                expv[i] = 2'b00;
            end else begin
                if (pend[i]) begin
                    build(i, s);
                    pend[i] = 1'b0;
                    expv[i] = 2'b00;
                end else if (mq[i].size() > 0) begin
                    expv[i] = mq[i].pop_front();
                end else begin
                    expv[i] = 2'b00;
                    if (e && !enp[i]) pend[i] = 1'b1;
                end
                enp[i] = e;
            end
        end
        #1;
        chk("cycle_u2", {ss0, ls0}, expv[0]);
        chk("cycle_u1", {ss1, ls1}, expv[1]);
    end

    task automatic pulse(input int i);
        @(negedge clk);
        if (i == 0) en0 = 1'b1; else en1 = 1'b1;
        @(negedge clk);
        if (i == 0) en0 = 1'b0; else en1 = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        bit done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (!pend[i] && mq[i].size() == 0) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: instance %0d still busy, required idle", i);
        end
    endtask

    // Capture dut0 outputs on n edges after raising en0, compare to a literal trace.
    task automatic trace_chk(input string name, input int n, input logic [1:0] ref_t [16]);
        logic [1:0] got [16];
        @(negedge clk);
        en0 = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #2;
            got[k] = {ss0, ls0};
        end
        @(negedge clk);
        en0 = 1'b0;
        for (int k = 0; k < n; k++) chk(name, got[k], ref_t[k]);
    endtask

    logic [1:0] tr_a [16] = '{0, 0, 2, 2, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    logic [1:0] tr_e [16] = '{0, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        rst = 1'b1;
        en0 = 1'b0; en1 = 1'b0;
        sw0 = 3'd0; sw1 = 3'd0;
        repeat (3) @(negedge clk);
        chk("reset_u2", {ss0, ls0}, 2'b00);
        chk("reset_u1", {ss1, ls1}, 2'b00);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // A: dot then dash, literal trace of 16 edges (en held, no retrigger).
        sw0 = 3'd0;
        trace_chk("trace_A", 16, tr_a);
        wait_idle(0);

        // E: single dot, ls never high.
        sw0 = 3'd4;
        trace_chk("trace_E", 8, tr_e);
        wait_idle(0);

        // C with sw change and extra en pulse mid-playback.
        sw0 = 3'd2;
        pulse(0);
        repeat (5) @(negedge clk);
        sw0 = 3'd7;
        pulse(0);
        wait_idle(0);
        repeat (4) @(negedge clk);

        // G with en held for 50 cycles, then a fresh edge.
        sw0 = 3'd6;
        @(negedge clk);
        en0 = 1'b1;
        repeat (50) @(negedge clk);
        en0 = 1'b0;
        wait_idle(0);
        pulse(0);
        wait_idle(0);

        // B, async reset during the second symbol (a dot).
        sw0 = 3'd1;
        @(negedge clk);
        en0 = 1'b1;
        repeat (11) @(posedge clk);
        #3;
        chk("pre_reset_dot", {ss0, ls0}, 2'b10);
        rst = 1'b1;
        #1;
        chk("async_reset", {ss0, ls0}, 2'b00);
        @(negedge clk);
        en0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        // en high when reset releases starts playback.
        rst = 1'b1;
        sw0 = 3'd3;
        en0 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        en0 = 1'b0;
        wait_idle(0);

        // Unit-1 sweep of all letters.
        for (int l = 0; l < 8; l++) begin
            sw1 = 3'(l);
            pulse(1);
            wait_idle(1);
        end

        // Random phase on both instances.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) en0 = ~en0;
            if ($urandom_range(0, 5) == 0) en1 = ~en1;
            if ($urandom_range(0, 9) == 0) sw0 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) sw1 = 3'($urandom_range(0, 7));
        end
        en0 = 1'b0;
        en1 = 1'b0;
        wait_idle(0);
        wait_idle(1);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/morse_blinker.md
# morse_blinker

Morse-code letter blinker for the lab board. A 3-bit switch value selects one letter, A through H. A rising edge on `en` plays that letter's Morse pattern on two LED outputs: `ss` lights for each dot and `ls` lights for each dash. The block is the top of a three-part datapath: a start/finish FSM, a switch-to-Morse decoder and a timed blink sequencer.

## Interface
- `UNIT_CYCLES`, default 25_000_000: length of one Morse time unit in clock cycles (0.5 s at 50 MHz). Must be ≥ 1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  start request; only its rising edge is used.
- `sw`  in  3  letter select: 0=A, 1=B, 2=C, 3=D, 4=E, 5=F, 6=G, 7=H.
- `ss`  out  1  short-signal LED; high during a dot.
- `ls`  out  1  long-signal LED; high during a dash.

## Operation
- **Decoder.** Combinational map from `sw` to a 4-bit code and a 3-bit length. Code bit 0 is the first symbol; bit value 1 means dash, 0 means dot. Unused code bits are 0.
  - A `.-` : length 2, code 0010
  - B `-...` : length 4, code 0001
  - C `-.-.` : length 4, code 0101
  - D `-..` : length 3, code 0001
  - E `.` : length 1, code 0000
  - F `..-.` : length 4, code 0100
  - G `--.` : length 3, code 0011
  - H `....` : length 4, code 0000
- **Edge detector.** `en_q` is a registered copy of `en`, reset to 0. A start is detected on any edge where `en`=1 and `en_q`=0.
- **FSM states.** IDLE, LOAD, ON, GAP.
  - IDLE: on a detected start, go to LOAD. Otherwise stay.
  - LOAD: latch the decoded code and length and clear the symbol index. Go to ON.
  - ON: drive the current symbol for its duration, then go to GAP.
  - GAP: outputs low for UNIT_CYCLES. Then, if more symbols remain, advance the index and go to ON. Otherwise raise the internal finish and go to IDLE.
- **Symbol durations.** A dot lasts UNIT_CYCLES. A dash lasts 3×UNIT_CYCLES.
- **Duration counter.** Wide enough for 3×UNIT_CYCLES; reloads at every state entry.
- **Outputs.** `ss` and `ls` are registered. `ss`=1 exactly while in ON with a dot; `ls`=1 exactly while in ON with a dash. They are never high at the same time.
- **Busy behaviour.**
  - Changes on `sw` after LOAD are ignored; the latched letter plays to completion.
  - `en` edges outside IDLE are ignored and are not queued.
  - `en` held high does not retrigger; a new 0→1 transition is required.
- **Reset behaviour.**
  - Reset at any time forces IDLE, `ss`=0, `ls`=0, `en_q`=0, counters and index to 0, and clears the latched code.
  - Reset mid-letter aborts the playback.
  - If `en` is high when reset deasserts, the first clock edge counts as a rising edge and starts playback.

## Timing
- Reset values: `ss`=0, `ls`=0, state IDLE.
- Start latency: edge E0 detects the start, edge E1 is LOAD, and from edge E2 the first symbol's output is high.
- Per symbol: output high for UNIT_CYCLES (dot) or 3×UNIT_CYCLES (dash), followed by UNIT_CYCLES low.
- After the last GAP the block is back in IDLE and accepts a new start at the next edge.
- Total busy cycles after LOAD: sum of symbol durations plus length×UNIT_CYCLES.

## Test plan
1. UNIT_CYCLES=2, `sw`=0 (A), pulse `en` → two cycles after the detect edge: `ss` high 2 cycles, low 2, `ls` high 6, low 2, then idle. 12 busy cycles, `ls` and `ss` never high together.
2. UNIT_CYCLES=2, `sw`=4 (E) → a single `ss` pulse of 2 cycles, 2-cycle gap, then idle. `ls` stays 0 throughout.
3. UNIT_CYCLES=2, `sw`=2 (C); toggle `sw` to 7 and pulse `en` again mid-playback → the full C pattern (dash dot dash dot) plays. No H pattern follows, and the extra `en` pulse is ignored.
4. UNIT_CYCLES=2, `sw`=6 (G), hold `en` high for 50 cycles → G plays exactly once. Releasing and re-raising `en` plays G again.
5. UNIT_CYCLES=2, assert `rst` asynchronously (between clock edges) during the second symbol of B → `ss`/`ls` drop to 0 immediately. After release, nothing plays until a new `en` rising edge.
6. UNIT_CYCLES=1, sweep `sw` from 0 to 7 with one `en` pulse each, waiting for idle → output pulse widths match the decoder map, with dot=1 cycle, dash=3 cycles and gap=1 cycle.
